bounce_gen: RTL
===============

# bounce_gen

Synthesizable switch-bounce emulator: takes a clean logic level and drives a bouncing version of it, with a pseudo-random number of toggles at pseudo-random spacing before settling on the new level. It is the stimulus-side counterpart of `debouncer`. It sits between a clean source (button model, FPGA test pattern) and a `debouncer` instance, for closed-loop hardware self-test and simulation without behavioural delays.

## Interface
- `MAX_BOUNCES`, default 20: maximum extra toggles per edge event; range 0..255.
- `MAX_GAP`, default 15: maximum clock cycles between toggles; range 1..255.
- `SETTLE_TICKS`, default 32: minimum cycles the final level is held before a new event is accepted; ≥1.
- `SEED`, default 16'hACE1: LFSR reset value; 0 is replaced by 16'h0001.

Ports:
- `clk` in 1: sole clock; all logic on posedge.
- `rst` in 1: asynchronous, active-low reset.
- `clean_in` in 1: clean level, synchronous to `clk`; no synchronizer inside.
- `bounce_out` out 1: emulated bouncing level; registered.
- `busy` out 1: high while an event is in progress (BOUNCE or SETTLE); registered.
- `bounce_count` out 8: toggles issued in the current or last event; registered.

## Operation
- LFSR: 16-bit Galois, mask 16'hB400, shifts right every cycle including IDLE; reset to `SEED` (or 1).
- Draws, taken from the LFSR value at the detect edge:
  - N = `lfsr[15:8] % (MAX_BOUNCES+1)`.
  - G = 1 + (`lfsr[7:0] % MAX_GAP`).
  - Gaps within one event all use the same G.
- States: IDLE, BOUNCE, SETTLE.
- IDLE:
  - If `clean_in` ≠ `bounce_out`: latch target = `clean_in`, remaining = N, `gap_cnt` = G, `bounce_count` = 0, go to BOUNCE.
  - Otherwise hold.
- BOUNCE:
  - If `gap_cnt` > 1: decrement.
  - Else if remaining > 0: toggle `bounce_out`, decrement remaining, increment `bounce_count`, reload `gap_cnt` = G.
  - Else: `bounce_out` = target, `settle_cnt` = `SETTLE_TICKS`, go to SETTLE.
- SETTLE: decrement `settle_cnt`; at 1, go to IDLE.
- `clean_in` changes during BOUNCE/SETTLE are ignored. Target stays latched. Any mismatch remaining on return to IDLE starts a fresh event on that IDLE edge.
- N = 0: no toggles; `bounce_out` goes to target after G cycles.
- `busy` = 1 exactly when state is BOUNCE or SETTLE.
- Counter widths: `gap_cnt` and remaining are 8 bits; `settle_cnt` is clog2(`SETTLE_TICKS`+1) bits. No overflow is possible within the parameter ranges.

## Timing
- Reset values: `bounce_out` = 0, `busy` = 0, `bounce_count` = 0, state IDLE, LFSR = seed.
- Event timeline, with detection at edge t:
  - `busy` rises at t.
  - Toggle k (1..N) lands at edge t + k·G.
  - Final level lands at t + (N+1)·G.
  - IDLE is entered at t + (N+1)·G + `SETTLE_TICKS`, and `busy` falls there.
- Minimum event length is 1 + `SETTLE_TICKS` cycles (N = 0, G = 1).
- Asserting `rst` mid-event aborts immediately and asynchronously to the reset values. After release, if `clean_in` = 1 an event starts on the first edge.

## Configuration
- `BOUNCE_GEN_FIXED_EN` defined: draws are replaced by constants, N = `MAX_BOUNCES` and G = `MAX_GAP`, giving deterministic waveforms for directed tests. The LFSR remains but has no effect on outputs.
- `BOUNCE_GEN_FIXED_EN` undefined: LFSR draws as described under Operation.

## Test plan
- FIXED, `MAX_BOUNCES`=4, `MAX_GAP`=3, `SETTLE_TICKS`=5: `clean_in` 0→1 detected at edge t.
  - `bounce_out` = 1, 0, 1, 0 at t+3, 6, 9, 12, then 1 at t+15.
  - `bounce_count` = 4.
  - `busy` is high from t until it falls at t+20.
- FIXED, `MAX_BOUNCES`=0, `MAX_GAP`=2: 0→1 detected at t → `bounce_out` = 1 at t+2, `bounce_count` = 0, no intermediate toggles.
- FIXED (4,3,5): `clean_in` pulses 1 then back to 0 at t+4.
  - Event completes with final 1 at t+15.
  - A second event starts at t+20 and ends with `bounce_out` = 0 at t+35.
- FIXED (4,3,5): `rst` asserted at t+7 → `bounce_out`, `busy`, `bounce_count` = 0 immediately. After release with `clean_in` = 1, a new event starts on the first edge.
- Random mode, defaults, 200 random edges of `clean_in` spaced > 400 cycles:
  - Every event has `bounce_count` ≤ 20, all gaps in 1..15, and final `bounce_out` = `clean_in`.
  - Through a `debouncer` with BOUNCE_TICKS=100, the output shows exactly one transition per edge.
- `SEED`=0 → LFSR never locks at zero; reset value observed as 16'h0001.

Source files
------------

// File: rtl/bounce_gen.sv
// bounce_gen: turns a clean level into a bouncing one (LFSR-drawn toggle count and spacing).
// Define BOUNCE_GEN_FIXED_EN to replace the draws with MAX_BOUNCES / MAX_GAP for deterministic waveforms.
module bounce_gen #(
  parameter int unsigned MAX_BOUNCES  = 20,
  parameter int unsigned MAX_GAP      = 15,
  parameter int unsigned SETTLE_TICKS = 32,
  parameter logic [15:0] SEED         = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clean_in,
  output logic       bounce_out,
  output logic       busy,
  output logic [7:0] bounce_count
);

  localparam int unsigned    SW          = $clog2(SETTLE_TICKS + 1);
  localparam logic [15:0]    SEED_EFF    = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [SW-1:0]  SETTLE_LOAD = SW'(SETTLE_TICKS);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_BOUNCE = 2'd1;
  localparam logic [1:0] ST_SETTLE = 2'd2;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    lfsr_next = (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  logic [1:0]    state_r, state_nxt_s;
  logic [15:0]   lfsr_r;
  logic          target_r, target_nxt_s;
  logic [7:0]    remain_r, remain_nxt_s;
  logic [7:0]    gap_r, gap_nxt_s;
  logic [7:0]    gap_ld_r, gap_ld_nxt_s;
  logic [SW-1:0] settle_r, settle_nxt_s;
  logic          out_r, out_nxt_s;
  logic          busy_r;
  logic [7:0]    count_r, count_nxt_s;
  logic [7:0]    draw_n_s, draw_g_s;
  logic          start_s;

`ifdef BOUNCE_GEN_FIXED_EN
  assign draw_n_s = 8'(MAX_BOUNCES);
  assign draw_g_s = 8'(MAX_GAP);
`else
  assign draw_n_s = 8'({1'b0, lfsr_r[15:8]} % 9'(MAX_BOUNCES + 1));
  assign draw_g_s = 8'd1 + (lfsr_r[7:0] % 8'(MAX_GAP));
`endif

  // An event starts from IDLE, or straight out of the last SETTLE cycle if the input moved meanwhile.
  assign start_s = (clean_in != out_r) &&
                   ((state_r == ST_IDLE) ||
                    ((state_r == ST_SETTLE) && (settle_r <= SW'(1))));

  // Next-state logic for the event sequencer.
  always_comb begin
    state_nxt_s  = state_r;
    target_nxt_s = target_r;
    remain_nxt_s = remain_r;
    gap_nxt_s    = gap_r;
    gap_ld_nxt_s = gap_ld_r;
    settle_nxt_s = settle_r;
    out_nxt_s    = out_r;
    count_nxt_s  = count_r;
    if (start_s) begin
      target_nxt_s = clean_in;
      remain_nxt_s = draw_n_s;
      gap_nxt_s    = draw_g_s;
      gap_ld_nxt_s = draw_g_s;
      count_nxt_s  = 8'd0;
      state_nxt_s  = ST_BOUNCE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_nxt_s = ST_IDLE;
        end
        ST_BOUNCE: begin
          if (gap_r > 8'd1) begin
            gap_nxt_s = gap_r - 8'd1;
          end else if (remain_r != 8'd0) begin
            out_nxt_s    = ~out_r;
            remain_nxt_s = remain_r - 8'd1;
            count_nxt_s  = count_r + 8'd1;
            gap_nxt_s    = gap_ld_r;
          end else begin
            out_nxt_s    = target_r;
            settle_nxt_s = SETTLE_LOAD;
            state_nxt_s  = ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (settle_r > SW'(1)) begin
            settle_nxt_s = settle_r - SW'(1);
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
        end
      endcase
    end
  end

  // State, LFSR and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r  <= ST_IDLE;
      lfsr_r   <= SEED_EFF;
      target_r <= 1'b0;
      remain_r <= 8'd0;
      gap_r    <= 8'd0;
      gap_ld_r <= 8'd0;
      settle_r <= '0;
      out_r    <= 1'b0;
      busy_r   <= 1'b0;
      count_r  <= 8'd0;
    end else begin
      state_r  <= state_nxt_s;
      lfsr_r   <= lfsr_next(lfsr_r);
      target_r <= target_nxt_s;
      remain_r <= remain_nxt_s;
      gap_r    <= gap_nxt_s;
      gap_ld_r <= gap_ld_nxt_s;
      settle_r <= settle_nxt_s;
      out_r    <= out_nxt_s;
      busy_r   <= (state_nxt_s != ST_IDLE);
      count_r  <= count_nxt_s;
    end
  end

  assign bounce_out   = out_r;
  assign busy         = busy_r;
  assign bounce_count = count_r;

endmodule
